load_store_unit: RTL

- Sits between the MEM-stage pipeline control and the word-addressed data memory (din/ADDR/WR_RD/dout).
- Converts MIPS byte-addressed load/store requests (LB/LBU/LH/LHU/LW/SB/SH/SW) into word accesses.
- Sign/zero-extends load data.
- Performs read-modify-write for sub-word stores, because the memory has only full-word writes.
- Reports misaligned or illegal requests without touching memory.

---
 rtl/load_store_unit_pkg.sv | 57 +++++
 rtl/load_store_unit_align.sv | 62 ++++++
 rtl/load_store_unit.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_pkg.sv
// Opcode, state and access-size definitions shared by the load/store unit and its lane aligner.
package load_store_unit_pkg;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0011;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_WRITE,
        ST_RESP
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD,
        SZ_NONE
    } lsu_size_t;

    function automatic lsu_size_t op_size(input logic [3:0] op);
        op_size = SZ_NONE;
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: op_size = SZ_HALF;
            OP_LW, OP_SW:         op_size = SZ_WORD;
            default:              op_size = SZ_NONE;
        endcase
    endfunction

    // Only meaningful for opcodes that op_size() recognises.
    function automatic logic op_is_store(input logic [3:0] op);
        return op[3];
    endfunction

    function automatic logic op_is_unsigned(input logic [3:0] op);
        return op[2];
    endfunction

    function automatic logic req_is_bad(input logic [3:0] op, input logic [1:0] addr_lo);
        req_is_bad = 1'b0;
        case (op_size(op))
            SZ_NONE: req_is_bad = 1'b1;
            SZ_HALF: req_is_bad = addr_lo[0];
            SZ_WORD: req_is_bad = |addr_lo;
            default: req_is_bad = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Big-endian byte-lane extraction with sign/zero extension, and sub-word store merge.
// Purely combinational; the caller registers the results.
module ls_align
    import load_store_unit_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sgn;

    always_comb begin
        byte_sel   = 8'h00;
        half_sel   = addr_lo[1] ? word[15:0] : word[31:16];
        sgn        = 1'b0;
        load_data  = word;
        store_word = word;

        // Offset 0 is the most significant byte.
        case (addr_lo)
            2'd0:    byte_sel = word[31:24];
            2'd1:    byte_sel = word[23:16];
            2'd2:    byte_sel = word[15:8];
            default: byte_sel = word[7:0];
        endcase

        case (op_size(op))
            SZ_BYTE: begin
                sgn       = ~op_is_unsigned(op) & byte_sel[7];
                load_data = {{24{sgn}}, byte_sel};
                case (addr_lo)
                    2'd0:    store_word[31:24] = wdata[7:0];
                    2'd1:    store_word[23:16] = wdata[7:0];
                    2'd2:    store_word[15:8]  = wdata[7:0];
                    default: store_word[7:0]   = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                sgn       = ~op_is_unsigned(op) & half_sel[15];
                load_data = {{16{sgn}}, half_sel};
                if (addr_lo[1]) begin
                    store_word[15:0] = wdata[15:0];
                end else begin
                    store_word[31:16] = wdata[15:0];
                end
            end
            SZ_WORD: begin
                store_word = wdata;
            end
            default: begin
                load_data = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MIPS byte-addressed loads/stores onto a word-only memory; sub-word stores use read-modify-write.
// Latency: error 1, SW 2, loads 2+RD_LAT, SB/SH 3+RD_LAT cycles; one request in flight, req_ready only in IDLE.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int RD_LAT = 1
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_rd,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    lsu_state_t        state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        wait_cnt_q, wait_cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_wr_rd_q, mem_wr_rd_d;
    logic [31:0]       mem_din_q, mem_din_d;

    logic [31:0]       load_data;
    logic [31:0]       store_word;
    logic              capture;
    logic              unused_addr_hi;

    // Byte addresses wrap modulo the memory size.
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    ls_align u_align (
        .op         (op_q),
        .addr_lo    (addr_lo_q),
        .word       (mem_dout),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_lo_d    = addr_lo_q;
        wdata_d      = wdata_q;
        wait_cnt_d   = wait_cnt_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wr_rd_d  = 1'b0;
        mem_din_d    = mem_din_q;
        capture      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    op_d        = req_op;
                    addr_lo_d   = req_addr[1:0];
                    wdata_d     = req_wdata;
                    mem_addr_d  = req_addr[ADDR_W+1:2];
                    if (req_is_bad(req_op, req_addr[1:0])) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_op == OP_SW) begin
                        state_d     = ST_WRITE;
                        mem_wr_rd_d = 1'b1;
                        mem_din_d   = req_wdata;
                    end else begin
                        state_d = ST_RD_ISSUE;
                    end
                end
            end
            ST_RD_ISSUE: begin
                if (RD_LAT == 0) begin
                    capture = 1'b1;
                end else begin
                    state_d    = ST_RD_WAIT;
                    wait_cnt_d = 2'(RD_LAT - 1);
                end
            end
            ST_RD_WAIT: begin
                if (wait_cnt_q == 2'd0) begin
                    capture = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end
            end
            ST_WRITE: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase

        // mem_dout is valid on this edge: either finish the load or launch the merged write.
        if (capture) begin
            if (op_is_store(op_q)) begin
                state_d     = ST_WRITE;
                mem_wr_rd_d = 1'b1;
                mem_din_d   = store_word;
            end else begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = load_data;
            end
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            op_q         <= 4'h0;
            addr_lo_q    <= 2'd0;
            wdata_q      <= 32'h0;
            wait_cnt_q   <= 2'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wr_rd_q  <= 1'b0;
            mem_din_q    <= 32'h0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_lo_q    <= addr_lo_d;
            wdata_q      <= wdata_d;
            wait_cnt_q   <= wait_cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_addr_q   <= mem_addr_d;
            mem_wr_rd_q  <= mem_wr_rd_d;
            mem_din_q    <= mem_din_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wr_rd  = mem_wr_rd_q;
    assign mem_din    = mem_din_q;

endmodule
